// File: rtl/data_island_scheduler.sv
// HDMI data island sequencer: arbitrates ACR / audio sample / AVI IF / audio IF
// packets and emits registered preamble, guard and packet strobes per pixel clock.
module data_island_scheduler #(
  parameter int unsigned MAX_PACKETS = 18,
  parameter int unsigned MIN_CONTROL = 12
) (
  input  logic        clk_pixel,
  input  logic        reset_n,
  input  logic        acr_toggle,
  input  logic        audio_ready,
  input  logic        frame_start,
  input  logic [11:0] blank_remaining,
  output logic        preamble,
  output logic        guard,
  output logic        packet_active,
  output logic [4:0]  packet_pixel,
  output logic [2:0]  packet_type,
  output logic        packet_grant,
  output logic        acr_overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_LEAD_GUARD, S_PACKET, S_TRAIL_GUARD
  } state_e;

  typedef enum logic [2:0] {
    PT_NONE = 3'd0, PT_ACR = 3'd1, PT_AUDIO = 3'd2, PT_AVI = 3'd3, PT_AIF = 3'd4
  } ptype_e;

  localparam logic [7:0] HOLD_INIT = 8'(MIN_CONTROL);
  localparam logic [4:0] MAX_PK    = 5'(MAX_PACKETS);

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [7:0] holdoff_q, holdoff_d;
  logic [4:0] pkt_cnt_q, pkt_cnt_d;
  logic       acr_prev_q, acr_prev_d;
  logic       acr_primed_q, acr_primed_d;
  logic       acr_pend_q, acr_pend_d;
  logic       avi_pend_q, avi_pend_d;
  logic       aif_pend_q, aif_pend_d;
  logic       acr_overrun_q, acr_overrun_d;
  ptype_e     type_q, type_d;
  logic       preamble_q, preamble_d;
  logic       guard_q, guard_d;
  logic       active_q, active_d;
  logic [4:0] pixel_q, pixel_d;
  logic       grant_q, grant_d;

  logic       acr_edge;
  logic [3:0] req;
  ptype_e     winner;
  logic       grant_now;

  always_comb begin
    acr_edge = acr_primed_q && (acr_toggle != acr_prev_q);
    req      = {acr_pend_q, audio_ready, avi_pend_q, aif_pend_q};
    if (req[3])      winner = PT_ACR;
    else if (req[2]) winner = PT_AUDIO;
    else if (req[1]) winner = PT_AVI;
    else if (req[0]) winner = PT_AIF;
    else             winner = PT_NONE;

    state_d   = state_q;
    cnt_d     = cnt_q;
    holdoff_d = holdoff_q;
    pkt_cnt_d = pkt_cnt_q;
    grant_now = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Decrement and test together so exactly MIN_CONTROL idle cycles elapse.
        holdoff_d = (holdoff_q == '0) ? '0 : holdoff_q - 8'd1;
        if (holdoff_d == '0 && req != '0 && blank_remaining >= 12'd44) begin
          state_d   = S_PREAMBLE;
          cnt_d     = '0;
          pkt_cnt_d = '0;
        end
      end
      S_PREAMBLE: begin
        if (cnt_q == 5'd7) begin
          state_d = S_LEAD_GUARD;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 5'd1;
      end
      S_LEAD_GUARD: begin
        if (cnt_q == 5'd1) begin
          cnt_d = '0;
          if (req != '0) begin
            grant_now = 1'b1;
            state_d   = S_PACKET;
          end else state_d = S_TRAIL_GUARD;
        end else cnt_d = cnt_q + 5'd1;
      end
      S_PACKET: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          if (req != '0 && pkt_cnt_q < MAX_PK && blank_remaining >= 12'd35)
            grant_now = 1'b1;
          else
            state_d = S_TRAIL_GUARD;
        end
      end
      S_TRAIL_GUARD: begin
        if (cnt_q == 5'd1) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          holdoff_d = HOLD_INIT;
        end else cnt_d = cnt_q + 5'd1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (grant_now) pkt_cnt_d = pkt_cnt_q + 5'd1;

    if (grant_now)              type_d = winner;
    else if (state_d == S_PACKET) type_d = type_q;
    else                        type_d = PT_NONE;

    // A new request in the same cycle as its grant survives the clear.
    acr_prev_d    = acr_toggle;
    acr_primed_d  = 1'b1;
    acr_pend_d    = acr_edge | (acr_pend_q & ~(grant_now && winner == PT_ACR));
    acr_overrun_d = acr_overrun_q |
                    (acr_edge & acr_pend_q & ~(grant_now && winner == PT_ACR));
    avi_pend_d    = frame_start | (avi_pend_q & ~(grant_now && winner == PT_AVI));
    aif_pend_d    = frame_start | (aif_pend_q & ~(grant_now && winner == PT_AIF));

    preamble_d = (state_d == S_PREAMBLE);
    guard_d    = (state_d == S_LEAD_GUARD) || (state_d == S_TRAIL_GUARD);
    active_d   = (state_d == S_PACKET);
    pixel_d    = active_d ? cnt_d : '0;
    grant_d    = grant_now;
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      holdoff_q     <= '0;
      pkt_cnt_q     <= '0;
      acr_prev_q    <= 1'b0;
      acr_primed_q  <= 1'b0;
      acr_pend_q    <= 1'b0;
      avi_pend_q    <= 1'b0;
      aif_pend_q    <= 1'b0;
      acr_overrun_q <= 1'b0;
      type_q        <= PT_NONE;
      preamble_q    <= 1'b0;
      guard_q       <= 1'b0;
      active_q      <= 1'b0;
      pixel_q       <= '0;
      grant_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      holdoff_q     <= holdoff_d;
      pkt_cnt_q     <= pkt_cnt_d;
      acr_prev_q    <= acr_prev_d;
      acr_primed_q  <= acr_primed_d;
      acr_pend_q    <= acr_pend_d;
      avi_pend_q    <= avi_pend_d;
      aif_pend_q    <= aif_pend_d;
      acr_overrun_q <= acr_overrun_d;
      type_q        <= type_d;
      preamble_q    <= preamble_d;
      guard_q       <= guard_d;
      active_q      <= active_d;
      pixel_q       <= pixel_d;
      grant_q       <= grant_d;
    end
  end

  assign preamble      = preamble_q;
  assign guard         = guard_q;
  assign packet_active = active_q;
  assign packet_pixel  = pixel_q;
  assign packet_type   = type_q;
  assign packet_grant  = grant_q;
  assign acr_overrun   = acr_overrun_q;

endmodule

// File: tb/tb_data_island_scheduler.sv
// Directed bench for data_island_scheduler; expected island waveforms are
// generated cycle-by-cycle from the island layout (8 preamble, 2 guard, 32/packet, 2 guard).
module tb_data_island_scheduler;

  logic        clk_pixel;
  logic        reset_n;
  logic        acr_toggle;
  logic        audio_ready;
  logic        frame_start;
  logic [11:0] blank_remaining;
  logic        preamble;
  logic        guard;
  logic        packet_active;
  logic [4:0]  packet_pixel;
  logic [2:0]  packet_type;
  logic        packet_grant;
  logic        acr_overrun;
  logic [11:0] obs;

  int tests = 0;
  int fails = 0;

  data_island_scheduler #(.MAX_PACKETS(18), .MIN_CONTROL(12)) dut (
    .clk_pixel      (clk_pixel),
    .reset_n        (reset_n),
    .acr_toggle     (acr_toggle),
    .audio_ready    (audio_ready),
    .frame_start    (frame_start),
    .blank_remaining(blank_remaining),
    .preamble       (preamble),
    .guard          (guard),
    .packet_active  (packet_active),
    .packet_pixel   (packet_pixel),
    .packet_type    (packet_type),
    .packet_grant   (packet_grant),
    .acr_overrun    (acr_overrun)
  );

  assign obs = {preamble, guard, packet_active, packet_pixel, packet_type, packet_grant};

  always #5 clk_pixel = ~clk_pixel;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk_pixel);
    #1;
  endtask

  // Expected {preamble,guard,active,pixel,type,grant} at offset i of an island
  function automatic logic [11:0] island_vec(input int i, input int npk, input logic [2:0] ty);
    int last;
    int pix;
    logic [4:0] p5;
    last = 12 + 32 * npk;
    if (i < 8) return 12'h800;
    if (i < 10 || i >= last - 2) return 12'h400;
    pix = (i - 10) % 32;
    p5  = pix[4:0];
    return {3'b001, p5, ty, (pix == 0)};
  endfunction

  task automatic wait_preamble(input int bound, output int waited, output bit seen);
    waited = 0;
    seen   = 0;
    while (waited < bound && !seen) begin
      tick();
      waited++;
      if (preamble === 1'b1) seen = 1;
    end
  endtask

  task automatic wait_grant(input int bound, output bit seen);
    int n;
    n    = 0;
    seen = 0;
    while (n < bound && !seen) begin
      tick();
      n++;
      if (packet_grant === 1'b1) seen = 1;
    end
  endtask

  task automatic test_reset;
    #3 reset_n = 1'b0;
    #1;
    tests++;
    if (obs !== 12'h000) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 12'h000);
    end
    tests++;
    if (acr_overrun !== 1'b0) begin
      fails++;
      $display("FAIL reset_overrun: got %b expected 0", acr_overrun);
    end
    tick(); tick(); tick();
    reset_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_single_acr;
    int  w;
    bit  seen;
    logic [11:0] exp;
    blank_remaining = 12'd100;
    acr_toggle = ~acr_toggle;
    wait_preamble(10, w, seen);
    tests++;
    if (!seen || w != 2) begin
      fails++;
      $display("FAIL acr_latency: seen=%0d after %0d cycles, expected seen after 2", seen, w);
    end
    for (int i = 0; i < 44; i++) begin
      exp = island_vec(i, 1, 3'd1);
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL acr_island[%0d]: got %h expected %h", i, obs, exp);
      end
      tick();
    end
    for (int j = 0; j < 20; j++) begin
      tests++;
      if (obs !== 12'h000) begin
        fails++;
        $display("FAIL acr_after_idle[%0d]: got %h expected 000", j, obs);
      end
      tick();
    end
  endtask

  task automatic test_multi_source;
    logic [2:0] types [4];
    logic [2:0] ty;
    logic [11:0] exp;
    int grants;
    types[0] = 3'd1; types[1] = 3'd2; types[2] = 3'd3; types[3] = 3'd4;
    grants = 0;
    blank_remaining = 12'd500;
    frame_start = 1'b1;
    acr_toggle  = ~acr_toggle;
    audio_ready = 1'b1;
    tick();
    frame_start = 1'b0;
    tests++;
    if (preamble !== 1'b1) begin
      fails++;
      $display("FAIL multi_start: preamble=%b expected 1", preamble);
    end
    for (int i = 0; i < 140; i++) begin
      ty  = (i >= 10 && i < 138) ? types[(i - 10) / 32] : 3'd0;
      exp = island_vec(i, 4, ty);
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL multi_island[%0d]: got %h expected %h", i, obs, exp);
      end
      if (packet_grant === 1'b1) grants++;
      if (i == 42) audio_ready = 1'b0;
      tick();
    end
    tests++;
    if (grants != 4) begin
      fails++;
      $display("FAIL multi_grants: got %0d expected 4", grants);
    end
    for (int j = 0; j < 20; j++) begin
      tests++;
      if (obs !== 12'h000) begin
        fails++;
        $display("FAIL multi_after_idle[%0d]: got %h expected 000", j, obs);
      end
      tick();
    end
  endtask

  task automatic test_max_packets;
    int w;
    bit seen;
    logic [11:0] exp;
    blank_remaining = 12'd1000;
    audio_ready = 1'b1;
    wait_preamble(5, w, seen);
    tests++;
    if (!seen || w != 1) begin
      fails++;
      $display("FAIL max_latency: seen=%0d after %0d cycles, expected seen after 1", seen, w);
    end
    for (int i = 0; i < 588; i++) begin
      exp = island_vec(i, 18, 3'd2);
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL max_island[%0d]: got %h expected %h", i, obs, exp);
      end
      tick();
    end
    for (int j = 0; j < 12; j++) begin
      tests++;
      if (obs !== 12'h000) begin
        fails++;
        $display("FAIL max_holdoff[%0d]: got %h expected 000", j, obs);
      end
      tick();
    end
    tests++;
    if (preamble !== 1'b1) begin
      fails++;
      $display("FAIL max_next_preamble: preamble=%b expected 1", preamble);
    end
    wait_grant(20, seen);
    audio_ready = 1'b0;
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL max_second_grant: no grant within 20 cycles, expected one");
    end
    for (int k = 0; k < 34; k++) tick();
    tests++;
    if (obs !== 12'h000) begin
      fails++;
      $display("FAIL max_drain: got %h expected 000", obs);
    end
    for (int k = 0; k < 15; k++) tick();
  endtask

  task automatic test_blank_limits;
    int w;
    bit seen;
    bit any_pre;
    blank_remaining = 12'd43;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    any_pre = 0;
    for (int k = 0; k < 30; k++) begin
      if (preamble === 1'b1) any_pre = 1;
      tick();
    end
    tests++;
    if (any_pre) begin
      fails++;
      $display("FAIL blank43_no_preamble: preamble seen=1 expected 0");
    end
    blank_remaining = 12'd44;
    wait_preamble(3, w, seen);
    tests++;
    if (!seen || w != 1) begin
      fails++;
      $display("FAIL blank44_start: seen=%0d after %0d cycles, expected seen after 1", seen, w);
    end
    wait_grant(20, seen);
    tests++;
    if (!seen || packet_type !== 3'd3) begin
      fails++;
      $display("FAIL blank_first_type: seen=%0d type=%0d expected type 3", seen, packet_type);
    end
    blank_remaining = 12'd34;
    for (int k = 0; k < 32; k++) tick();
    tests++;
    if (obs !== 12'h400) begin
      fails++;
      $display("FAIL blank34_trail: got %h expected 400", obs);
    end
    tick(); tick();
    tests++;
    if (obs !== 12'h000) begin
      fails++;
      $display("FAIL blank34_idle: got %h expected 000", obs);
    end
    any_pre = 0;
    for (int k = 0; k < 30; k++) begin
      if (preamble === 1'b1) any_pre = 1;
      tick();
    end
    tests++;
    if (any_pre) begin
      fails++;
      $display("FAIL blank34_hold: preamble seen=1 expected 0");
    end
    blank_remaining = 12'd100;
    wait_preamble(15, w, seen);
    tests++;
    if (!seen || w != 1) begin
      fails++;
      $display("FAIL blank_resume: seen=%0d after %0d cycles, expected seen after 1", seen, w);
    end
    wait_grant(20, seen);
    tests++;
    if (!seen || packet_type !== 3'd4) begin
      fails++;
      $display("FAIL blank_aif_type: seen=%0d type=%0d expected type 4", seen, packet_type);
    end
    for (int k = 0; k < 50; k++) tick();
  endtask

  task automatic test_overrun;
    bit seen;
    bit any_pre;
    int grants;
    tests++;
    if (acr_overrun !== 1'b0) begin
      fails++;
      $display("FAIL overrun_pre: got %b expected 0", acr_overrun);
    end
    blank_remaining = 12'd100;
    acr_toggle = ~acr_toggle;
    tick();
    acr_toggle = ~acr_toggle;
    tick();
    tests++;
    if (acr_overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_set: got %b expected 1", acr_overrun);
    end
    wait_grant(20, seen);
    tests++;
    if (!seen || packet_type !== 3'd1) begin
      fails++;
      $display("FAIL overrun_acr_type: seen=%0d type=%0d expected type 1", seen, packet_type);
    end
    grants = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (packet_grant === 1'b1) grants++;
    end
    tests++;
    if (grants != 0) begin
      fails++;
      $display("FAIL overrun_extra_grants: got %0d expected 0", grants);
    end
    tests++;
    if (acr_overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_sticky: got %b expected 1", acr_overrun);
    end
    reset_n = 1'b0;
    acr_toggle = 1'b1;
    tick(); tick();
    reset_n = 1'b1;
    tests++;
    if (acr_overrun !== 1'b0) begin
      fails++;
      $display("FAIL overrun_cleared: got %b expected 0", acr_overrun);
    end
    any_pre = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (preamble === 1'b1) any_pre = 1;
    end
    tests++;
    if (any_pre) begin
      fails++;
      $display("FAIL unprimed_acr: preamble seen=1 expected 0");
    end
  endtask

  task automatic test_reset_mid_packet;
    bit seen;
    bit any_pre;
    blank_remaining = 12'd100;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_grant(20, seen);
    tests++;
    if (!seen || packet_type !== 3'd3) begin
      fails++;
      $display("FAIL midrst_grant: seen=%0d type=%0d expected type 3", seen, packet_type);
    end
    for (int k = 0; k < 5; k++) tick();
    tests++;
    if (packet_active !== 1'b1 || packet_pixel !== 5'd5) begin
      fails++;
      $display("FAIL midrst_pre_state: active=%b pixel=%0d expected active 1 pixel 5", packet_active, packet_pixel);
    end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (obs !== 12'h000 || acr_overrun !== 1'b0) begin
      fails++;
      $display("FAIL midrst_async: got %h ovr=%b expected 000 ovr=0", obs, acr_overrun);
    end
    tick(); tick();
    reset_n = 1'b1;
    any_pre = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (preamble === 1'b1 || packet_active === 1'b1) any_pre = 1;
    end
    tests++;
    if (any_pre) begin
      fails++;
      $display("FAIL midrst_pending_cleared: activity seen=1 expected 0");
    end
  endtask

  initial begin
    clk_pixel       = 1'b0;
    reset_n         = 1'b1;
    acr_toggle      = 1'b0;
    audio_ready     = 1'b0;
    frame_start     = 1'b0;
    blank_remaining = 12'd0;
    test_reset();
    test_single_acr();
    test_multi_source();
    test_max_packets();
    test_blank_limits();
    test_overrun();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
